// File: rtl/isqrt_rr_scheduler.sv
// isqrt_rr_scheduler: round-robin sharing of one pipelined isqrt among N requesters with tag-routed results; define ISQRT_RR_SCHEDULER_CHECK_EN to enable the sticky err check
module isqrt_rr_scheduler #(
    parameter int N = 3,
    parameter int LATENCY = 4,
    parameter int W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_vld,
    input  logic [N*W-1:0]     req_x,
    output logic [N-1:0]       req_rdy,
    output logic               sq_x_vld,
    output logic [W-1:0]       sq_x,
    input  logic               sq_y_vld,
    input  logic [W/2-1:0]     sq_y,
    output logic [N-1:0]       res_vld,
    output logic [N*(W/2)-1:0] res,
    output logic               err
);
    localparam int H = W / 2;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr, nxt_ptr;
    logic [N-1:0]  grant;
    logic [W-1:0]  sel_x;
    logic [N-1:0]  tag [LATENCY+1];
    logic [N-1:0]  tag_out;

    function automatic int wrap_idx(input int p, input int i);
        return (p + i) % N;
    endfunction

    // first valid request at or after ptr wins; scanning backwards lets the nearest one overwrite
    always_comb begin
        grant = '0;
        nxt_ptr = ptr;
        sel_x = sq_x;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_vld[wrap_idx(int'(ptr), i)]) begin
                grant = '0;
                grant[wrap_idx(int'(ptr), i)] = 1'b1;
                nxt_ptr = PW'((wrap_idx(int'(ptr), i) + 1) % N);
                sel_x = req_x[wrap_idx(int'(ptr), i)*W +: W];
            end
        end
    end

    assign req_rdy = grant;
    assign tag_out = tag[LATENCY];

    // input register, pointer and tag shadow pipeline; sq_x holds while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            sq_x_vld <= 1'b0;
            sq_x <= '0;
            for (int j = 0; j <= LATENCY; j++) tag[j] <= '0;
        end else begin
            ptr <= nxt_ptr;
            sq_x_vld <= |grant;
            sq_x <= sel_x;
            tag[0] <= grant;
            for (int j = 1; j <= LATENCY; j++) tag[j] <= tag[j-1];
        end
    end

    // result register: only the owning slice loads, others hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_vld <= '0;
            res <= '0;
        end else begin
            res_vld <= sq_y_vld ? tag_out : '0;
            for (int k = 0; k < N; k++)
                if (sq_y_vld && tag_out[k]) res[k*H +: H] <= sq_y;
        end
    end

`ifdef ISQRT_RR_SCHEDULER_CHECK_EN
    // sticky flag when isqrt output valid disagrees with the shadow tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (sq_y_vld != |tag_out) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_isqrt_rr_scheduler.sv
// tb_isqrt_rr_scheduler: randomized and directed checks of the isqrt round-robin scheduler against a queue-based model
module tb_isqrt_rr_scheduler;
    localparam int N = 3;
    localparam int L = 4;
    localparam int W = 32;
    localparam int H = W / 2;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req_vld, req_rdy, res_vld;
    logic [N*W-1:0] req_x;
    logic sq_x_vld, sq_y_vld, err;
    logic [W-1:0] sq_x;
    logic [H-1:0] sq_y;
    logic [N*H-1:0] res;
    int pass_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    isqrt_rr_scheduler #(.N(N), .LATENCY(L), .W(W)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
        .sq_x_vld(sq_x_vld), .sq_x(sq_x), .sq_y_vld(sq_y_vld), .sq_y(sq_y),
        .res_vld(res_vld), .res(res), .err(err)
    );

    function automatic logic [H-1:0] isqrt_f(input logic [W-1:0] x);
        longint r = 0;
        longint t;
        for (int b = H - 1; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= longint'(x)) r = t;
        end
        return H'(r);
    endfunction

    // behavioural isqrt with a run-time selectable latency, sharing rst with the DUT
    int stub_lat = L;
    logic [7:0] p_vld;
    logic [H-1:0] p_y [8];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_vld <= '0;
            for (int i = 0; i < 8; i++) p_y[i] <= '0;
        end else begin
            p_vld <= {p_vld[6:0], sq_x_vld};
            p_y[0] <= isqrt_f(sq_x);
            for (int i = 1; i < 8; i++) p_y[i] <= p_y[i-1];
        end
    end
    assign sq_y_vld = p_vld[stub_lat-1];
    assign sq_y = p_y[stub_lat-1];

    typedef struct { int due; int k; logic [H-1:0] y; } pend_t;
    pend_t q[$];
    int m_ptr = 0;
    int cyc = 0;
    logic [N-1:0] exp_vld = '0;
    logic [N*H-1:0] exp_res = '0;
    logic [W-1:0] exp_sqx = '0;
    logic exp_sqv = 1'b0;

    function automatic logic [N-1:0] arb(input logic [N-1:0] v, input int p);
        logic [N-1:0] g = '0;
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) begin
                g[(p + i) % N] = 1'b1;
                return g;
            end
        return g;
    endfunction

    task automatic tick();
        logic [N-1:0] g;
        g = arb(req_vld, m_ptr);
        @(posedge clk);
        cyc++;
        exp_vld = '0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].due == cyc) begin
                exp_vld[q[i].k] = 1'b1;
                exp_res[q[i].k*H +: H] = q[i].y;
                q.delete(i);
            end
        exp_sqv = |g;
        for (int k = 0; k < N; k++)
            if (g[k]) begin
                q.push_back('{cyc + L + 1, k, isqrt_f(req_x[k*W +: W])});
                m_ptr = (k + 1) % N;
                exp_sqx = req_x[k*W +: W];
            end
        #1;
    endtask

    task automatic clear_model();
        q.delete();
        m_ptr = 0;
        exp_vld = '0;
        exp_res = '0;
        exp_sqx = '0;
        exp_sqv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        req_vld = '0;
        req_x = '0;
        rst = 1'b1;
        clear_model();
        #2;
        chk_cnt++; if (res_vld !== '0) $display("FAIL reset res_vld got %b want 0", res_vld); else pass_cnt++;
        chk_cnt++; if (res !== '0) $display("FAIL reset res got %h want 0", res); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL reset err got %b want 0", err); else pass_cnt++;
        chk_cnt++; if (sq_x_vld !== 1'b0) $display("FAIL reset sq_x_vld got %b want 0", sq_x_vld); else pass_cnt++;
        chk_cnt++; if (req_rdy !== '0) $display("FAIL reset req_rdy got %b want 0", req_rdy); else pass_cnt++;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        req_vld = 3'b001;
        req_x[0 +: W] = 144;
        #1;
        chk_cnt++; if (req_rdy !== 3'b001) $display("FAIL single req_rdy got %b want 001", req_rdy); else pass_cnt++;
        tick();
        req_vld = '0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk_cnt++;
            if (res_vld !== ((i == 5) ? 3'b001 : 3'b000))
                $display("FAIL single res_vld cycle %0d got %b want %b", i, res_vld, (i == 5) ? 3'b001 : 3'b000);
            else pass_cnt++;
            chk_cnt++; if (res !== exp_res) $display("FAIL single res cycle %0d got %h want %h", i, res, exp_res); else pass_cnt++;
        end
        chk_cnt++; if (res[0 +: H] !== 16'd12) $display("FAIL single res0 got %0d want 12", res[0 +: H]); else pass_cnt++;
    endtask

    task automatic test_contention();
        do_reset();
        req_vld = 3'b111;
        req_x = {32'd25, 32'd16, 32'd9};
        for (int i = 0; i < 12; i++) begin
            #1;
            chk_cnt++;
            if (req_rdy !== 3'(1 << (i % 3))) $display("FAIL contention grant %0d got %b want %b", i, req_rdy, 3'(1 << (i % 3)));
            else pass_cnt++;
            tick();
            chk_cnt++; if (res_vld !== exp_vld) $display("FAIL contention res_vld %0d got %b want %b", i, res_vld, exp_vld); else pass_cnt++;
            chk_cnt++; if (res !== exp_res) $display("FAIL contention res %0d got %h want %h", i, res, exp_res); else pass_cnt++;
            if (i >= 6) begin
                chk_cnt++;
                if (res_vld !== 3'(1 << ((i - 5) % 3))) $display("FAIL contention order %0d got %b want %b", i, res_vld, 3'(1 << ((i - 5) % 3)));
                else pass_cnt++;
            end
        end
        chk_cnt++; if (res !== {16'd5, 16'd4, 16'd3}) $display("FAIL contention values got %h want 000500040003", res); else pass_cnt++;
        req_vld = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_cnt++; if (res_vld !== exp_vld) $display("FAIL contention drain res_vld got %b want %b", res_vld, exp_vld); else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req_vld = 3'b010;
        req_x = {32'd1, 32'd4, 32'd100};
        #1;
        tick();
        req_vld = 3'b011;
        #1;
        chk_cnt++; if (req_rdy !== 3'b001) $display("FAIL wrap grant got %b want 001", req_rdy); else pass_cnt++;
        tick();
        #1;
        chk_cnt++; if (req_rdy !== 3'b010) $display("FAIL wrap next grant got %b want 010", req_rdy); else pass_cnt++;
        tick();
        req_vld = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_cnt++; if (res_vld !== exp_vld) $display("FAIL wrap res_vld got %b want %b", res_vld, exp_vld); else pass_cnt++;
            chk_cnt++; if (res !== exp_res) $display("FAIL wrap res got %h want %h", res, exp_res); else pass_cnt++;
        end
    endtask

    task automatic test_idle();
        req_vld = 3'b001;
        req_x[0 +: W] = 777;
        #1;
        tick();
        req_vld = '0;
        for (int i = 0; i < 10; i++) begin
            req_x = {$urandom, $urandom, $urandom};
            #1;
            tick();
            chk_cnt++; if (sq_x !== 32'd777) $display("FAIL idle sq_x got %0d want 777", sq_x); else pass_cnt++;
            chk_cnt++; if (sq_x_vld !== 1'b0) $display("FAIL idle sq_x_vld got %b want 0", sq_x_vld); else pass_cnt++;
            chk_cnt++; if (res !== exp_res) $display("FAIL idle res got %h want %h", res, exp_res); else pass_cnt++;
            chk_cnt++; if (res_vld !== exp_vld) $display("FAIL idle res_vld got %b want %b", res_vld, exp_vld); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            req_vld = N'($urandom_range(0, (1 << N) - 1));
            for (int k = 0; k < N; k++)
                req_x[k*W +: W] = (i % 2) ? $urandom : W'($urandom_range(0, 1000));
            #1;
            chk_cnt++; if (req_rdy !== arb(req_vld, m_ptr)) $display("FAIL random grant got %b want %b", req_rdy, arb(req_vld, m_ptr)); else pass_cnt++;
            chk_cnt++; if ((req_rdy & ~req_vld) !== '0) $display("FAIL random idle grant got %b req %b", req_rdy, req_vld); else pass_cnt++;
            tick();
            chk_cnt++; if (res_vld !== exp_vld) $display("FAIL random res_vld got %b want %b", res_vld, exp_vld); else pass_cnt++;
            chk_cnt++; if (res !== exp_res) $display("FAIL random res got %h want %h", res, exp_res); else pass_cnt++;
            chk_cnt++; if (sq_x_vld !== exp_sqv) $display("FAIL random sq_x_vld got %b want %b", sq_x_vld, exp_sqv); else pass_cnt++;
            chk_cnt++; if (sq_x !== exp_sqx) $display("FAIL random sq_x got %h want %h", sq_x, exp_sqx); else pass_cnt++;
            chk_cnt++; if (err !== 1'b0) $display("FAIL random err got %b want 0", err); else pass_cnt++;
        end
        req_vld = '0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_vld = 3'b111;
        req_x = {32'd49, 32'd36, 32'd81};
        for (int i = 0; i < 3; i++) begin
            #1;
            tick();
        end
        req_vld = '0;
        rst = 1'b1;
        #1;
        chk_cnt++; if (res_vld !== '0) $display("FAIL midflight during rst res_vld got %b want 0", res_vld); else pass_cnt++;
        clear_model();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_cnt++; if (res_vld !== '0) $display("FAIL midflight res_vld cycle %0d got %b want 0", i, res_vld); else pass_cnt++;
        end
        req_vld = 3'b111;
        #1;
        chk_cnt++; if (req_rdy !== 3'b001) $display("FAIL midflight grant got %b want 001", req_rdy); else pass_cnt++;
        req_vld = '0;
        #1;
    endtask

    task automatic test_check();
        logic want;
`ifdef ISQRT_RR_SCHEDULER_CHECK_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        do_reset();
        stub_lat = 5;
        req_vld = 3'b010;
        req_x[W +: W] = 64;
        #1;
        tick();
        req_vld = '0;
        for (int i = 0; i < 10; i++) tick();
        chk_cnt++; if (err !== want) $display("FAIL check err got %b want %b", err, want); else pass_cnt++;
        for (int i = 0; i < 5; i++) tick();
        chk_cnt++; if (err !== want) $display("FAIL check sticky err got %b want %b", err, want); else pass_cnt++;
        stub_lat = L;
        do_reset();
        chk_cnt++; if (err !== 1'b0) $display("FAIL check err after rst got %b want 0", err); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_idle();
        test_random();
        test_reset_midflight();
        test_check();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
